// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement subtractor (diff = a - b).
// One result bit per clock, LSB first, through a single full adder fed with
// ~b and a registered carry preset to 1 (the +1 of the two's complement).
// Reports unsigned borrow and signed overflow alongside the result.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             last;
    logic             nb;
    logic             s;
    logic             cout;

    // start only counts while not shifting; a request mid-SHIFT is dropped
    assign accept = start && (state == IDLE || state == DONE);
    assign last   = (state == SHIFT) && (cnt == LAST);

    // The single 1-bit full adder: a + ~b + carry
    assign nb   = ~sb[0];
    assign s    = sa[0] ^ nb ^ carry;
    assign cout = (sa[0] & nb) | (sa[0] & carry) | (nb & carry);

    // New sum bit enters at the MSB so the LSB-first stream lands in place
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_nxt = s;
        end else begin : g_res_wn
            assign res_nxt = {s, res[WIDTH-1:1]};
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state; done is the single DONE cycle
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            SHIFT:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Operand capture, bit-serial datapath and result publication.
    // On the MSB bit the live carry register is the carry into the MSB, so
    // overflow is formed from it and cout directly on that edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sa       <= '0;
            sb       <= '0;
            res      <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            diff     <= '0;
            borrow   <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            sa    <= a;
            sb    <= b;
            carry <= 1'b1;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            sa    <= sa >> 1;
            sb    <= sb >> 1;
            res   <= res_nxt;
            carry <= cout;
            cnt   <= cnt + 1'b1;
            if (last) begin
                diff     <= res_nxt;
                borrow   <= ~cout;
                overflow <= carry ^ cout;
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed vectors for WIDTH=8 plus an exhaustive
// WIDTH=4 sweep against a behavioural a - b reference.
`timescale 1ns/1ps
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow;
    logic       overflow;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       busy4;
    logic       done4;
    logic [3:0] diff4;
    logic       borrow4;
    logic       overflow4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow(borrow), .overflow(overflow)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4), .overflow(overflow4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; the accept edge is the next posedge.
    task automatic launch(input logic [7:0] va, input logic [7:0] vb);
        start = 1'b1;
        a     = va;
        b     = vb;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts negedges until done (bounded); returns at the done negedge.
    task automatic wait_done(output int ncyc, output int nbusy);
        ncyc  = 0;
        nbusy = 0;
        while (!done && ncyc < 20) begin
            if (busy) nbusy++;
            @(negedge clk);
            ncyc++;
        end
        if (!done) chk("done_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic op8(input string tag, input logic [7:0] va, input logic [7:0] vb,
                       input int exp_cyc, input logic [7:0] ed, input logic eb, input logic eo);
        int n;
        int nb;
        launch(va, vb);
        wait_done(n, nb);
        chk({tag, "_lat"},  n, exp_cyc);
        chk({tag, "_busy"}, nb, exp_cyc);
        chk({tag, "_diff"}, {24'd0, diff}, {24'd0, ed});
        chk({tag, "_brw"},  {31'd0, borrow}, {31'd0, eb});
        chk({tag, "_ovf"},  {31'd0, overflow}, {31'd0, eo});
    endtask

    initial begin
        int n;
        int nb;
        int pulses;
        int si;
        int sj;
        int sd;
        rst_n  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        start4 = 1'b0;
        a4     = '0;
        b4     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_diff", {24'd0, diff}, 32'd0);
        chk("rst_brw",  {31'd0, borrow}, 32'd0);
        chk("rst_ovf",  {31'd0, overflow}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic vectors
        op8("v1", 8'd5, 8'd3, 8, 8'h02, 1'b0, 1'b0);
        @(negedge clk);
        chk("v1_done_pulse", {31'd0, done}, 32'd0);
        chk("v1_idle_busy",  {31'd0, busy}, 32'd0);
        chk("v1_hold_diff",  {24'd0, diff}, 32'h02);
        op8("v2", 8'd3, 8'd5, 8, 8'hFE, 1'b1, 1'b0);
        @(negedge clk);
        op8("v3", 8'h80, 8'h01, 8, 8'h7F, 1'b0, 1'b1);
        @(negedge clk);
        op8("v4", 8'h7F, 8'hFF, 8, 8'h80, 1'b1, 1'b1);
        @(negedge clk);
        op8("v5", 8'h00, 8'h00, 8, 8'h00, 1'b0, 1'b0);
        @(negedge clk);

        // start mid-SHIFT with other operands is ignored
        launch(8'd5, 8'd3);
        @(negedge clk);
        start = 1'b1;
        a     = 8'h80;
        b     = 8'h01;
        @(negedge clk);
        start = 1'b0;
        wait_done(n, nb);
        chk("mid_lat",  n, 6);
        chk("mid_diff", {24'd0, diff}, 32'h02);
        chk("mid_brw",  {31'd0, borrow}, 32'd0);
        chk("mid_ovf",  {31'd0, overflow}, 32'd0);
        @(negedge clk);

        // Back-to-back: restart on the DONE cycle
        op8("b2b1", 8'h80, 8'h01, 8, 8'h7F, 1'b0, 1'b1);
        op8("b2b2", 8'd3, 8'd5, 8, 8'hFE, 1'b1, 1'b0);
        @(negedge clk);

        // Reset in the middle of SHIFT
        launch(8'd5, 8'd3);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("rmid_busy", {31'd0, busy}, 32'd0);
        chk("rmid_diff", {24'd0, diff}, 32'd0);
        chk("rmid_brw",  {31'd0, borrow}, 32'd0);
        chk("rmid_ovf",  {31'd0, overflow}, 32'd0);
        chk("rmid_nodone", pulses, 0);
        rst_n = 1'b1;
        op8("rrel", 8'h80, 8'h01, 8, 8'h7F, 1'b0, 1'b1);
        @(negedge clk);

        // Exhaustive WIDTH=4, consecutive operations restart from DONE
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                start4 = 1'b1;
                a4     = 4'(i);
                b4     = 4'(j);
                @(negedge clk);
                start4 = 1'b0;
                n = 0;
                while (!done4 && n < 10) begin
                    @(negedge clk);
                    n++;
                end
                si = (i >= 8) ? i - 16 : i;
                sj = (j >= 8) ? j - 16 : j;
                sd = si - sj;
                chk("w4_done", {31'd0, done4}, 32'd1);
                chk("w4_lat",  n, 4);
                chk("w4_diff", {28'd0, diff4}, 32'((i - j) & 15));
                chk("w4_brw",  {31'd0, borrow4}, (i < j) ? 32'd1 : 32'd0);
                chk("w4_ovf",  {31'd0, overflow4}, (sd < -8 || sd > 7) ? 32'd1 : 32'd0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
